// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Read-only bus initiator for a synchronous SRAM port. On a start strobe it
//   walks word_count consecutive word addresses beginning at base_addr, reads
//   each word, and presents it on a valid/ready stream along with the address
//   it came from. It takes the place of a core's data-memory port on the
//   memory-side mux so memory can be dumped after a run.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, abort      command strobe / cancel of the running dump
//   base_addr         first word address (sampled with start)
//   word_count        number of words to read (sampled with start)
//   busy, done        activity flag / one-cycle completion pulse
//   mem_oe, mem_web   SRAM output enable / byte write enables (active-low)
//   mem_addr, mem_DI  SRAM address / write data (never written)
//   mem_DO            SRAM read data, valid the cycle after it is addressed
//   out_valid/ready   stream handshake
//   out_data/addr     word read and the address it was read from
module mem_dump_reader #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4,
  parameter int CNT_SIZE  = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [CNT_SIZE-1:0]  word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_oe,
  output logic [BYTES-1:0]     mem_web,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_DI,
  input  logic [WORD_SIZE-1:0] mem_DO,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_SIZE-1:0] out_addr
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OUT,
    DONE
  } state_t;

  localparam logic [ADDR_SIZE-1:0] STEP = ADDR_SIZE'(ADDR_STEP);
  localparam logic [CNT_SIZE-1:0]  ONE  = CNT_SIZE'(1);

  state_t               state_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [CNT_SIZE-1:0]  remaining_reg;
  logic [ADDR_SIZE-1:0] addr_next;

  // Natural modulo-2^ADDR_SIZE wrap is the intended behaviour at the top of
  // the address space.
  assign addr_next = addr_reg + STEP;

  // The reader never writes the SRAM.
  assign mem_web = '1;
  assign mem_DI  = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_oe        <= 1'b0;
      mem_addr      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_addr      <= '0;
    end else if (abort && state_reg != IDLE) begin
      // Cancel wins over everything, including a handshake in the same
      // cycle; a held word is simply dropped and no done pulse is given.
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_oe    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (word_count != '0) begin
              addr_reg      <= base_addr;
              remaining_reg <= word_count;
              // Drive the SRAM request already in the READ cycle so the
              // SRAM samples it on the READ exit edge.
              mem_addr      <= base_addr;
              mem_oe        <= 1'b1;
              busy          <= 1'b1;
              state_reg     <= READ;
            end else begin
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        READ: begin
          // Request is on the bus; data appears during WAIT.
          state_reg <= WAIT;
        end

        WAIT: begin
          out_data  <= mem_DO;
          out_addr  <= addr_reg;
          out_valid <= 1'b1;
          mem_oe    <= 1'b0;
          state_reg <= OUT;
        end

        OUT: begin
          if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
            remaining_reg <= remaining_reg - ONE;
            addr_reg      <= addr_next;
            if (remaining_reg > ONE) begin
              mem_addr  <= addr_next;
              mem_oe    <= 1'b1;
              state_reg <= READ;
            end else begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_oe    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
